// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer_pkg                                           |
// | Purpose  : Shared constants for the fetch sequencer: state encodings,    |
// |            PC step, reset vector and branch-target alignment helper.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fetch_sequencer_pkg;

    localparam int          c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] S_FETCH   = 3'd0;
    localparam logic [c_STATE_W-1:0] S_DECODE  = 3'd1;
    localparam logic [c_STATE_W-1:0] S_EXECUTE = 3'd2;
    localparam logic [c_STATE_W-1:0] S_COMMIT  = 3'd3;
    localparam logic [c_STATE_W-1:0] S_HALTED  = 3'd4;

    localparam int          c_PC_W         = 16;
    localparam logic [15:0] c_PC_INC       = 16'd2;
    localparam logic [15:0] c_RESET_VECTOR = 16'h0000;

    // Instructions are halfword aligned, so a branch target never carries bit 0.
    function automatic logic [15:0] align_target(input logic [15:0] target);
        return {target[15:1], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_unit                                                       |
// | Purpose  : Program counter register with branch-load / increment mux.    |
// | Ports    : clk, rst (async, active-high)                                 |
// |            i_update - commit strobe, PC may change only when high        |
// |            i_load   - take i_target (aligned) instead of stepping        |
// |            i_target - branch target                                      |
// |            i_inc    - step PC by the increment when not loading          |
// |            o_pc     - current program counter                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pc_unit
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_update,
    input  logic              i_load,
    input  logic [c_PC_W-1:0] i_target,
    input  logic              i_inc,
    output logic [c_PC_W-1:0] o_pc
);

    logic [c_PC_W-1:0] r_pc;
    logic [c_PC_W-1:0] w_next_pc;

    // A load wins over stepping; without either the PC simply holds.
    // The add wraps naturally at 16 bits (0xFFFE -> 0x0000).
    always_comb begin
        w_next_pc = r_pc;
        if (i_load) begin
            w_next_pc = align_target(i_target);
        end else if (i_inc) begin
            w_next_pc = r_pc + c_PC_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= c_RESET_VECTOR;
        end else if (i_update) begin
            r_pc <= w_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                               |
// | Purpose  : Four-phase instruction sequencer (FETCH/DECODE/EXECUTE/       |
// |            COMMIT) with halt-at-boundary and single-step debug commands. |
// | Ports    : CLK, RESET (async, active-high)                               |
// |            MEM_WAIT          - stretches FETCH                           |
// |            PC_LOAD, PC_IN    - branch request/target, used in COMMIT     |
// |            HALT_REQ, RUN_REQ - stop at boundary / resume                 |
// |            DBG_VALID, DBG_OP_IN, DBG_ADDR_INC_IN, DBG_READY - debug cmd  |
// |            ADDR, RD          - fetch address and read strobe             |
// |            FETCH..COMMIT     - one-hot phase strobes                     |
// |            PC, DEBUG_MODE, DEBUG_OP, DEBUG_ADDR_INC, HALTED - status     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_WAIT,
    input  logic        PC_LOAD,
    input  logic [15:0] PC_IN,
    input  logic        HALT_REQ,
    input  logic        RUN_REQ,
    input  logic        DBG_VALID,
    input  logic [2:0]  DBG_OP_IN,
    input  logic        DBG_ADDR_INC_IN,
    output logic        DBG_READY,
    output logic [15:0] ADDR,
    output logic        RD,
    output logic        FETCH,
    output logic        DECODE,
    output logic        EXECUTE,
    output logic        COMMIT,
    output logic [15:0] PC,
    output logic        DEBUG_MODE,
    output logic [2:0]  DEBUG_OP,
    output logic        DEBUG_ADDR_INC,
    output logic        HALTED
);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_halt_pending;
    logic                 r_debug_mode;
    logic [2:0]           r_debug_op;
    logic                 r_debug_addr_inc;

    logic                 w_commit;
    logic                 w_halt_now;
    logic                 w_pc_inc;
    logic [15:0]          w_pc;

    assign w_commit   = (r_state == S_COMMIT);
    // A halt request arriving in the COMMIT cycle itself still stops at this
    // boundary; a debug instruction always returns to HALTED.
    assign w_halt_now = r_halt_pending | HALT_REQ | r_debug_mode;
    // Normal instructions always step; debug instructions step only on request.
    assign w_pc_inc   = ~r_debug_mode | r_debug_addr_inc;

    pc_unit u_pc_unit (
        .clk      (CLK),
        .rst      (RESET),
        .i_update (w_commit),
        .i_load   (PC_LOAD),
        .i_target (PC_IN),
        .i_inc    (w_pc_inc),
        .o_pc     (w_pc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state          <= S_FETCH;
            r_halt_pending   <= 1'b0;
            r_debug_mode     <= 1'b0;
            r_debug_op       <= 3'd0;
            r_debug_addr_inc <= 1'b0;
        end else begin
            r_halt_pending <= r_halt_pending | HALT_REQ;
            case (r_state)
                S_FETCH: begin
                    if (!MEM_WAIT) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE:  r_state <= S_EXECUTE;
                S_EXECUTE: r_state <= S_COMMIT;
                S_COMMIT: begin
                    if (w_halt_now) begin
                        r_state        <= S_HALTED;
                        r_halt_pending <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (DBG_VALID) begin
                        r_state          <= S_FETCH;
                        r_debug_mode     <= 1'b1;
                        r_debug_op       <= DBG_OP_IN;
                        r_debug_addr_inc <= DBG_ADDR_INC_IN;
                    end else if (RUN_REQ) begin
                        r_state      <= S_FETCH;
                        r_debug_mode <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Strobes decode straight from the state register so they change only on
    // clock edges and EXECUTE spans one full period.
    assign FETCH          = (r_state == S_FETCH);
    assign DECODE         = (r_state == S_DECODE);
    assign EXECUTE        = (r_state == S_EXECUTE);
    assign COMMIT         = w_commit;
    assign HALTED         = (r_state == S_HALTED);
    assign RD             = FETCH;
    assign ADDR           = w_pc;
    assign PC             = w_pc;
    // Acceptance is same-cycle so the handshake never leaks outside HALTED.
    assign DBG_READY      = HALTED & DBG_VALID;
    assign DEBUG_MODE     = r_debug_mode;
    assign DEBUG_OP       = r_debug_op;
    assign DEBUG_ADDR_INC = r_debug_addr_inc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_sequencer                                            |
// | Purpose  : Self-checking bench for fetch_sequencer: directed scenarios   |
// |            followed by randomized stimulus against a behavioural model.  |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_WAIT, PC_LOAD, HALT_REQ, RUN_REQ, DBG_VALID, DBG_ADDR_INC_IN;
    logic [15:0] PC_IN;
    logic [2:0]  DBG_OP_IN;
    logic        DBG_READY, RD, FETCH, DECODE, EXECUTE, COMMIT;
    logic        DEBUG_MODE, DEBUG_ADDR_INC, HALTED;
    logic [15:0] ADDR, PC;
    logic [2:0]  DEBUG_OP;

    always #5 CLK = ~CLK;

    fetch_sequencer dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .MEM_WAIT        (MEM_WAIT),
        .PC_LOAD         (PC_LOAD),
        .PC_IN           (PC_IN),
        .HALT_REQ        (HALT_REQ),
        .RUN_REQ         (RUN_REQ),
        .DBG_VALID       (DBG_VALID),
        .DBG_OP_IN       (DBG_OP_IN),
        .DBG_ADDR_INC_IN (DBG_ADDR_INC_IN),
        .DBG_READY       (DBG_READY),
        .ADDR            (ADDR),
        .RD              (RD),
        .FETCH           (FETCH),
        .DECODE          (DECODE),
        .EXECUTE         (EXECUTE),
        .COMMIT          (COMMIT),
        .PC              (PC),
        .DEBUG_MODE      (DEBUG_MODE),
        .DEBUG_OP        (DEBUG_OP),
        .DEBUG_ADDR_INC  (DEBUG_ADDR_INC),
        .HALTED          (HALTED)
    );

    // Phase names used by the reference model.
    localparam int P_FETCH   = 0;
    localparam int P_DECODE  = 1;
    localparam int P_EXECUTE = 2;
    localparam int P_COMMIT  = 3;
    localparam int P_HALTED  = 4;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state.
    int       m_phase;
    int       m_pc;
    bit       m_pend;
    bit       m_dm;
    bit [2:0] m_op;
    bit       m_inc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic clear_stim();
        MEM_WAIT = 0; PC_LOAD = 0; PC_IN = 16'h0; HALT_REQ = 0; RUN_REQ = 0;
        DBG_VALID = 0; DBG_OP_IN = 3'd0; DBG_ADDR_INC_IN = 0;
    endtask

    task automatic model_reset();
        m_phase = P_FETCH; m_pc = 0; m_pend = 0; m_dm = 0; m_op = 3'd0; m_inc = 0;
    endtask

    task automatic check_outputs();
        check("fetch",   FETCH,   m_phase == P_FETCH);
        check("decode",  DECODE,  m_phase == P_DECODE);
        check("execute", EXECUTE, m_phase == P_EXECUTE);
        check("commit",  COMMIT,  m_phase == P_COMMIT);
        check("halted",  HALTED,  m_phase == P_HALTED);
        check("pc",      PC,      m_pc);
        check("dbg_mode", DEBUG_MODE, m_dm);
        check("dbg_op",  DEBUG_OP, m_op);
        check("dbg_inc", DEBUG_ADDR_INC, m_inc);
        check("dbg_ready", DBG_READY, (m_phase == P_HALTED) && DBG_VALID);
        if (m_phase == P_FETCH) begin
            check("addr", ADDR, m_pc);
            check("rd_fetch", RD, 1);
        end
        if (m_phase == P_HALTED) check("rd_halted", RD, 0);
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit pend_now;
        pend_now = m_pend || HALT_REQ;
        m_pend   = pend_now;
        case (m_phase)
            P_FETCH:   if (!MEM_WAIT) m_phase = P_DECODE;
            P_DECODE:  m_phase = P_EXECUTE;
            P_EXECUTE: m_phase = P_COMMIT;
            P_COMMIT: begin
                if (PC_LOAD) m_pc = int'(PC_IN) - (int'(PC_IN) % 2);
                else if (!m_dm || m_inc) m_pc = (m_pc + 2) % 65536;
                if (pend_now || m_dm) begin
                    m_phase = P_HALTED;
                    m_pend  = 0;
                end else begin
                    m_phase = P_FETCH;
                end
            end
            default: begin
                if (DBG_VALID) begin
                    m_op = DBG_OP_IN; m_inc = DBG_ADDR_INC_IN; m_dm = 1; m_phase = P_FETCH;
                end else if (RUN_REQ) begin
                    m_dm = 0; m_phase = P_FETCH;
                end
            end
        endcase
    endtask

    // Called at a falling edge with the stimulus already set.
    task automatic step();
        #1;
        check_outputs();
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle_step();
        clear_stim();
        step();
    endtask

    task automatic run_to(input int phase);
        int n;
        n = 0;
        while (m_phase != phase && n < 20) begin
            idle_step();
            n++;
        end
        if (m_phase != phase) check("run_to_timeout", 0, 1);
    endtask

    task automatic do_reset();
        RESET = 1;
        clear_stim();
        #1;
        model_reset();
        check_outputs();
        check("rst_addr", ADDR, 16'h0000);
        @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        RESET = 0;
    endtask

    initial begin
        int pc_before;
        clear_stim();
        do_reset();

        // Free run: three instructions, PC 0,2,4 at COMMITs.
        repeat (12) idle_step();

        // Memory wait stretches FETCH for 3 extra cycles.
        run_to(P_FETCH);
        MEM_WAIT = 1; step();
        MEM_WAIT = 1; step();
        MEM_WAIT = 1; step();
        idle_step();

        // Branch with odd target, then wrap from 0xFFFE.
        run_to(P_COMMIT);
        PC_LOAD = 1; PC_IN = 16'h1235; step();
        check("branch_addr", ADDR, 16'h1234);
        run_to(P_COMMIT);
        PC_LOAD = 1; PC_IN = 16'hFFFE; step();
        run_to(P_COMMIT);
        idle_step();
        check("wrap_pc", PC, 16'h0000);

        // Halt request during DECODE completes the instruction then stops.
        run_to(P_DECODE);
        HALT_REQ = 1; step();
        run_to(P_HALTED);
        repeat (3) idle_step();
        check("halt_state", HALTED, 1);

        // Single debug instruction with auto-increment.
        pc_before = int'(PC);
        DBG_VALID = 1; DBG_OP_IN = 3'd5; DBG_ADDR_INC_IN = 1; step();
        run_to(P_EXECUTE);
        check("dbg_op_exec", DEBUG_OP, 3'd5);
        run_to(P_HALTED);
        check("dbg_pc_inc", PC, (pc_before + 2) % 65536);

        // Resume, then reset in the middle of EXECUTE.
        RUN_REQ = 1; step();
        run_to(P_EXECUTE);
        do_reset();
        repeat (5) idle_step();

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                MEM_WAIT        = ($urandom_range(0, 9) < 3);
                PC_LOAD         = ($urandom_range(0, 9) == 0);
                PC_IN           = 16'($urandom);
                HALT_REQ        = ($urandom_range(0, 29) == 0);
                RUN_REQ         = ($urandom_range(0, 9) < 3);
                DBG_VALID       = ($urandom_range(0, 9) < 2);
                DBG_OP_IN       = 3'($urandom);
                DBG_ADDR_INC_IN = 1'($urandom);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have the following ports; all are active-high unless stated.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- MEM_WAIT  in  1  memory not ready; stretches the FETCH phase.
- PC_LOAD  in  1  branch request, sampled in COMMIT.
- PC_IN  in  16  branch target, sampled in COMMIT.
- HALT_REQ  in  1  request a stop at the next instruction boundary.
- RUN_REQ  in  1  leave HALTED and resume free running.
- DBG_VALID  in  1  debug command offered.
- DBG_OP_IN  in  3  debug opcode.
- DBG_ADDR_INC_IN  in  1  debug auto-increment request.
- DBG_READY  out  1  debug command accepted (1-cycle pulse).
- ADDR  out  16  instruction fetch address (the current PC).
- RD  out  1  memory read strobe.
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  one-hot phase strobes; EXECUTE drives the instruction latch.
- PC  out  16  program counter.
- DEBUG_MODE  out  1  the current instruction is a debug command.
- DEBUG_OP  out  3  registered debug opcode for the current instruction.
- DEBUG_ADDR_INC  out  1  registered auto-increment flag.
- HALTED  out  1  the sequencer is stopped at an instruction boundary.

Function
REQ-002 SHALL implement these states: S_FETCH, S_DECODE, S_EXECUTE, S_COMMIT, S_HALTED.
REQ-003 SHALL assert exactly one of FETCH, DECODE, EXECUTE, COMMIT in each of the four run states; none are asserted in S_HALTED.
REQ-004 SHALL, in S_FETCH, drive ADDR=PC and RD=1, and stay in S_FETCH while MEM_WAIT=1; otherwise it moves to S_DECODE.
REQ-005 SHALL advance S_DECODE->S_EXECUTE->S_COMMIT unconditionally, one cycle each.
REQ-006 SHALL hold EXECUTE high for one full clock period, so a downstream latch on the falling clock edge samples it exactly once.
REQ-007 SHALL update PC in S_COMMIT:
- PC_LOAD=1: PC<=PC_IN with bit0 forced to 0.
- otherwise: PC<=PC+2, modulo 2^16 (0xFFFE wraps to 0x0000).
REQ-008 SHALL latch HALT_REQ into a sticky pending flag in any state; the flag clears on entry to S_HALTED.
REQ-009 SHALL, from S_COMMIT, go to S_HALTED if the pending flag is set or DEBUG_MODE=1; otherwise it goes to S_FETCH.
REQ-010 SHALL hold PC, DEBUG_OP and DEBUG_ADDR_INC, drive RD=0 and drive HALTED=1 while in S_HALTED.
REQ-011 SHALL resolve inputs in S_HALTED with priority DBG_VALID > RUN_REQ.
- DBG_VALID: pulse DBG_READY for one cycle, capture DBG_OP_IN and DBG_ADDR_INC_IN, set DEBUG_MODE=1, go to S_FETCH.
- RUN_REQ alone: clear DEBUG_MODE, go to S_FETCH.
REQ-012 SHALL keep DBG_READY at 0 outside S_HALTED; DBG_VALID is ignored there.
REQ-013 SHALL hold DEBUG_MODE, DEBUG_OP and DEBUG_ADDR_INC constant across FETCH..COMMIT of the debug instruction.
REQ-014 SHALL, when HALT_REQ and PC_LOAD are both active in COMMIT, perform the branch and then halt; HALTED PC equals the branch target.
REQ-015 SHALL, when a debug instruction has DEBUG_ADDR_INC=1, apply PC+2 in its COMMIT; otherwise PC is unchanged after a debug instruction unless PC_LOAD=1.
REQ-016 SHALL let MEM_WAIT extend only S_FETCH; it is ignored in all other states.

Reset
REQ-017 SHALL on RESET, at any time including mid-instruction:
- set state to S_FETCH, PC=0x0000, and clear the pending-halt flag;
- drive ADDR=0, RD=1, FETCH=1, other phase strobes 0;
- drive DEBUG_MODE=0, DEBUG_OP=0, DEBUG_ADDR_INC=0, HALTED=0, DBG_READY=0.
REQ-018 SHALL begin fetching at address 0x0000 on the first rising edge after RESET is released.

Structure
REQ-019 SHALL take its state encodings, the PC increment (2) and the reset vector (0x0000) from the shared constants file.
REQ-020 SHALL contain one sub-module, pc_unit, which holds the PC register and its increment/load mux; the state machine stays in fetch_sequencer.

Verification
REQ-021 SHALL cover these directed scenarios:
- Free run, no wait: the phase strobes cycle with period 4, EXECUTE is 1 cycle, and PC goes 0,2,4 at successive COMMITs.
- MEM_WAIT=1 for 3 cycles in FETCH: FETCH stays high for 4 cycles, and ADDR is stable at the PC value.
- PC_LOAD=1 with PC_IN=0x1235 in COMMIT: the next ADDR is 0x1234; with PC=0xFFFE and no load, the next PC is 0x0000.
- HALT_REQ pulse in DECODE: the current instruction completes, HALTED=1 after COMMIT, RD=0, and PC is held.
- Halted, then DBG_VALID with DBG_OP_IN=5 and DBG_ADDR_INC_IN=1: DBG_READY pulses, one instruction runs with DEBUG_MODE=1 and DEBUG_OP=5, PC increments by 2, and the sequencer re-enters HALTED.
- RESET asserted during EXECUTE: outputs take their reset values immediately, and fetching restarts at 0x0000.
